// File: rtl/spi_pkg.sv
// Shared types and constants for the on-chip SPI master that talks to spiMemory.
package spi_pkg;

    localparam int SPI_ADDR_W     = 7;
    localparam int SPI_DATA_W     = 8;
    localparam int SPI_FRAME_BITS = 16;

    localparam logic SPI_RW_READ  = 1'b1;
    localparam logic SPI_RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } spi_mst_state_t;

    // Build the 16-bit frame: address, rw flag, then data (zero on reads).
    function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
        input logic                  rw,
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_DATA_W-1:0] wdata
    );
        logic [SPI_DATA_W-1:0] data;
        data = (rw == SPI_RW_READ) ? '0 : wdata;
        return {addr, rw, data};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: toggles sclk every CLK_DIV enabled cycles and flags the
// cycle in which each rising or falling sclk edge is being registered.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic             half_done;

    assign half_done = en && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_tick = half_done && !sclk;
    assign fall_tick = half_done && sclk;

    // Count out each half period; held cleared (sclk low) whenever disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (half_done) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: turns single-byte read/write requests into 16-bit
// frames on the spiMemory pin interface and returns a one-cycle response.
//
// Request handshake: a transfer happens on a rising clk edge where both
// req_valid and req_ready are high. req_valid may be raised at any time and
// must stay high (with stable fields) until that edge; req_ready does not
// depend on req_valid. Fields are captured only at the handshake edge.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int CS_GAP  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [SPI_ADDR_W-1:0] req_addr,
    input  logic [SPI_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [SPI_DATA_W-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  sclk_pin,
    output logic                  cs_pin,
    output logic                  mosi_pin,
    input  logic                  miso_pin
);

    // The GAP state lasts one cycle less than the chip-select gap so that a
    // waiting request is accepted exactly GAP_CYC cycles after cs_pin rises.
    localparam int GAP_CYC = 2 * CLK_DIV * CS_GAP;
    localparam int GAP_W   = $clog2(GAP_CYC);

    spi_mst_state_t            state;
    logic [SPI_FRAME_BITS-1:0] shreg;
    logic [SPI_DATA_W-1:0]     rx_sh;
    logic                      rw_q;
    logic [4:0]                bit_cnt;
    logic [GAP_W-1:0]          gap_cnt;
    logic                      sclk_en;
    logic                      rise_tick;
    logic                      fall_tick;

    // The divider starts once cs_pin has dropped, one cycle after the handshake.
    assign sclk_en = (state == SHIFT) && !cs_pin;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (sclk_en),
        .sclk      (sclk_pin),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Frame sequencer: handshake, shift 16 bits out/in, then hold the cs gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            cs_pin    <= 1'b1;
            mosi_pin  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            shreg     <= '0;
            rx_sh     <= '0;
            rw_q      <= SPI_RW_WRITE;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        shreg     <= spi_frame(req_rw, req_addr, req_wdata);
                        rw_q      <= req_rw;
                        bit_cnt   <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_pin) begin
                        // Frame start: select the slave and present bit 15.
                        cs_pin   <= 1'b0;
                        mosi_pin <= shreg[SPI_FRAME_BITS-1];
                    end else begin
                        if (rise_tick) begin
                            rx_sh <= {rx_sh[SPI_DATA_W-2:0], miso_pin};
                        end
                        if (fall_tick) begin
                            shreg    <= shreg << 1;
                            mosi_pin <= shreg[SPI_FRAME_BITS-2];
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'(SPI_FRAME_BITS - 1)) begin
                                // rx_sh now holds the samples of rising edges 9..16.
                                cs_pin    <= 1'b1;
                                mosi_pin  <= 1'b0;
                                rsp_valid <= 1'b1;
                                rsp_rdata <= (rw_q == SPI_RW_READ) ? rx_sh : '0;
                                gap_cnt   <= '0;
                                state     <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 2)) begin
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural spiMemory slave model.
// Instance a uses the default divider, instance b uses CLK_DIV=2.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic       req_valid, req_valid_b;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;

    logic       req_ready, rsp_valid, busy, sclk_pin, cs_pin, mosi_pin, miso_pin;
    logic [7:0] rsp_rdata;
    logic       req_ready_b, rsp_valid_b, busy_b, sclk_pin_b, cs_pin_b, mosi_pin_b, miso_pin_b;
    logic [7:0] rsp_rdata_b;

    spi_master_ctrl #(.CLK_DIV(8), .CS_GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin), .miso_pin(miso_pin)
    );

    spi_master_ctrl #(.CLK_DIV(2), .CS_GAP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b),
        .sclk_pin(sclk_pin_b), .cs_pin(cs_pin_b), .mosi_pin(mosi_pin_b), .miso_pin(miso_pin_b)
    );

    // ---------------- slave models (spiMemory behaviour) ----------------
    logic [7:0]  mem_a [128];
    logic [7:0]  mem_b [128];
    logic [15:0] sf_a = '0, sf_b = '0, last_frame_a = '0, last_frame_b = '0;
    logic [6:0]  sa_a = '0, sa_b = '0;
    int          sc_a = 0, sc_b = 0;

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        miso_pin   = 1'b0;
        miso_pin_b = 1'b0;
    end

    always @(posedge sclk_pin) if (cs_pin === 1'b0) begin
        sf_a = {sf_a[14:0], mosi_pin};
        sc_a++;
        if (sc_a == 7) sa_a = sf_a[6:0];
        if (sc_a == 16) begin
            last_frame_a = sf_a;
            if (sf_a[8] == SPI_RW_WRITE) mem_a[sf_a[15:9]] = sf_a[7:0];
        end
    end
    always @(negedge sclk_pin) if (cs_pin === 1'b0 && sc_a >= 8 && sc_a <= 15)
        miso_pin = mem_a[sa_a][15-sc_a];
    always @(posedge cs_pin) begin
        sc_a = 0;
        miso_pin = 1'b0;
    end

    always @(posedge sclk_pin_b) if (cs_pin_b === 1'b0) begin
        sf_b = {sf_b[14:0], mosi_pin_b};
        sc_b++;
        if (sc_b == 7) sa_b = sf_b[6:0];
        if (sc_b == 16) begin
            last_frame_b = sf_b;
            if (sf_b[8] == SPI_RW_WRITE) mem_b[sf_b[15:9]] = sf_b[7:0];
        end
    end
    always @(negedge sclk_pin_b) if (cs_pin_b === 1'b0 && sc_b >= 8 && sc_b <= 15)
        miso_pin_b = mem_b[sa_b][15-sc_b];
    always @(posedge cs_pin_b) begin
        sc_b = 0;
        miso_pin_b = 1'b0;
    end

    // ---------------- monitors ----------------
    logic cs_prev = 1'b1, sb_prev = 1'b0;
    int   cs_rise_edge = 0, rsp_cnt = 0, sb_rise = 0, sb_rise_prev = 0;
    logic overlap_seen = 1'b0;

    always @(posedge clk) begin
        cs_prev <= cs_pin;
        if (cs_pin === 1'b1 && cs_prev === 1'b0) cs_rise_edge <= cyc - 1;
        if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
        if (req_ready === 1'b1 && busy === 1'b1) overlap_seen <= 1'b1;
        sb_prev <= sclk_pin_b;
        if (sclk_pin_b === 1'b1 && sb_prev === 1'b0) begin
            sb_rise_prev <= sb_rise;
            sb_rise      <= cyc;
        end
    end

    // ---------------- scoreboard counters / checker ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Raise req_valid and hold it until the handshake edge; scramble fields after.
    task automatic send(input bit use_b, input logic rw, input logic [6:0] a,
                        input logic [7:0] d, output int hs_edge);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        hs_edge = -1;
        req_rw = rw;
        req_addr = a;
        req_wdata = d;
        if (use_b) req_valid_b = 1'b1;
        else       req_valid   = 1'b1;
        while (!got && n < 1000) begin
            @(posedge clk);
            got = use_b ? (req_ready_b === 1'b1) : (req_ready === 1'b1);
            hs_edge = cyc;
            n++;
        end
        #1;
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        req_rw      = 1'($urandom_range(0, 1));
        req_addr    = 7'($urandom_range(0, 127));
        req_wdata   = 8'($urandom_range(0, 255));
        check("handshake", 32'(got), 32'd1);
    endtask

    // Wait (bounded) for the response pulse; report its edge and data.
    task automatic wait_rsp(input bit use_b, output logic [7:0] data, output int edge_no);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        data = 'x;
        edge_no = -1;
        while (!got && n < 1000) begin
            @(posedge clk);
            #1;
            if ((use_b ? rsp_valid_b : rsp_valid) === 1'b1) begin
                got = 1'b1;
                data = use_b ? rsp_rdata_b : rsp_rdata;
                edge_no = cyc - 1;
            end
            n++;
        end
        check("rsp_seen", 32'(got), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int         hs, re, rsp_before, rises, n;
        int         hs_t[3];
        logic [7:0] rd;
        bit         prev_s;

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_valid_b = 1'b0;
        req_rw = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'(cs_pin), 32'd1);
        check("rst_sclk", 32'(sclk_pin), 32'd0);
        check("rst_mosi", 32'(mosi_pin), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);
        check("busy_after_rst", 32'(busy), 32'd0);

        // Write 0x01 to 0x00
        send(1'b0, SPI_RW_WRITE, 7'h00, 8'h01, hs);
        check("hs_busy", 32'(busy), 32'd1);
        check("hs_ready_low", 32'(req_ready), 32'd0);
        check("cs_still_high_t0", 32'(cs_pin), 32'd1);
        @(posedge clk);
        #1;
        check("cs_low_t0p1", 32'(cs_pin), 32'd0);
        check("mosi_bit15", 32'(mosi_pin), 32'd0);
        wait_rsp(1'b0, rd, re);
        check("wr_rsp_latency", 32'(re - hs), 32'd257);
        check("wr_rdata_zero", 32'(rd), 32'h00);
        check("wr_frame", 32'(last_frame_a), 32'h0001);
        check("cs_high_at_rsp", 32'(cs_pin), 32'd1);

        // Read 0x00
        send(1'b0, SPI_RW_READ, 7'h00, 8'hA5, hs);
        wait_rsp(1'b0, rd, re);
        check("rd0_data", 32'(rd), 32'h01);
        check("rd0_frame", 32'(last_frame_a), 32'h0100);

        // Write 0x0F to 0x07, read 0x07, re-read 0x00
        send(1'b0, SPI_RW_WRITE, 7'h07, 8'h0F, hs);
        wait_rsp(1'b0, rd, re);
        check("wr7_frame", 32'(last_frame_a), 32'h0E0F);
        send(1'b0, SPI_RW_READ, 7'h07, 8'hFF, hs);
        wait_rsp(1'b0, rd, re);
        check("rd7_data", 32'(rd), 32'h0F);
        check("rd7_frame", 32'(last_frame_a), 32'h0F00);
        send(1'b0, SPI_RW_READ, 7'h00, 8'h00, hs);
        wait_rsp(1'b0, rd, re);
        check("rd0_again", 32'(rd), 32'h01);
        repeat (20) @(posedge clk);
        #1;
        check("rdata_hold", 32'(rsp_rdata), 32'h01);

        // Three back-to-back requests with req_valid held high
        req_valid = 1'b1;
        req_rw = SPI_RW_WRITE;
        req_addr = 7'h10;
        req_wdata = 8'h33;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            hs_t[i] = -1;
            while (hs_t[i] < 0 && n < 1000) begin
                @(posedge clk);
                if (req_ready === 1'b1) hs_t[i] = cyc;
                n++;
            end
            #1;
            check("b2b_handshake", 32'(hs_t[i] >= 0), 32'd1);
            if (i > 0) begin
                check("b2b_spacing", 32'(hs_t[i] - hs_t[i-1]), 32'd273);
                check("b2b_cs_gap", 32'(hs_t[i] - cs_rise_edge), 32'd16);
            end
            if (i == 0) begin
                req_addr = 7'h11;
                req_wdata = 8'h44;
            end else if (i == 1) begin
                req_rw = SPI_RW_READ;
                req_addr = 7'h10;
                req_wdata = 8'h00;
            end
        end
        req_valid = 1'b0;
        wait_rsp(1'b0, rd, re);
        check("b2b_rd_data", 32'(rd), 32'h33);
        check("b2b_rsp_latency", 32'(re - hs_t[2]), 32'd257);
        send(1'b0, SPI_RW_READ, 7'h11, 8'h00, hs);
        wait_rsp(1'b0, rd, re);
        check("b2b_rd11", 32'(rd), 32'h44);

        // CLK_DIV=2 instance
        send(1'b1, SPI_RW_WRITE, 7'h07, 8'h0F, hs);
        wait_rsp(1'b1, rd, re);
        check("div2_wr_latency", 32'(re - hs), 32'd65);
        send(1'b1, SPI_RW_READ, 7'h07, 8'h00, hs);
        wait_rsp(1'b1, rd, re);
        check("div2_rd7", 32'(rd), 32'h0F);
        check("div2_frame", 32'(last_frame_b), 32'h0F00);
        check("div2_sclk_period", 32'(sb_rise - sb_rise_prev), 32'd4);

        // Reset in the middle of a read, right at sclk rising edge 10
        send(1'b0, SPI_RW_READ, 7'h07, 8'h00, hs);
        rises = 0;
        n = 0;
        prev_s = 1'b0;
        while (rises < 10 && n < 2000) begin
            @(posedge clk);
            #1;
            if (sclk_pin === 1'b1 && !prev_s) rises++;
            prev_s = (sclk_pin === 1'b1);
            n++;
        end
        check("mid_rise10_reached", 32'(rises), 32'd10);
        rsp_before = rsp_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs", 32'(cs_pin), 32'd1);
        check("mid_rst_sclk", 32'(sclk_pin), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("mid_no_rsp", 32'(rsp_cnt - rsp_before), 32'd0);
        send(1'b0, SPI_RW_READ, 7'h00, 8'h00, hs);
        wait_rsp(1'b0, rd, re);
        check("post_rst_rd0", 32'(rd), 32'h01);

        check("ready_busy_exclusive", 32'(overlap_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI master sequencer that drives the existing `spiMemory` slave from on-chip logic rather than from pins. It accepts single-byte read/write requests over a valid/ready handshake and generates `sclk_pin`, `cs_pin` and `mosi_pin`. It samples `miso_pin` and returns read data with a one-cycle response pulse. It sits between a host FSM or CPU bus and the `spiMemory` pin interface.

## Interface
- `CLK_DIV`, default 8: `clk` cycles per `sclk_pin` half-period; legal range 2..255.
- `CS_GAP`, default 1: full `sclk` periods that `cs_pin` stays high between frames; legal range ≥1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_rw`  in  1  1 = read, 0 = write.
- `req_addr`  in  7  memory address.
- `req_wdata`  in  8  write data; ignored on reads.
- `rsp_valid`  out  1  one-cycle pulse when a frame completes (reads and writes).
- `rsp_rdata`  out  8  read data; valid with `rsp_valid` on reads, 0 on writes.
- `busy`  out  1  high from handshake until the `cs_pin` gap ends.
- `sclk_pin`  out  1  SPI clock; idles low.
- `cs_pin`  out  1  chip select, active-low.
- `mosi_pin`  out  1  master-out data.
- `miso_pin`  in  1  slave-out data.

## Operation
- Frame = 16 bits, MSB first.
  - Bits 15..9: `req_addr[6:0]`.
  - Bit 8: `req_rw`.
  - Bits 7..0: `req_wdata` on writes; constant 0 on reads.
- States and transitions:
  - IDLE: `req_ready`=1. On `req_valid & req_ready`, latch `req_rw`, `req_addr`, `req_wdata`, then go to SHIFT.
  - SHIFT: `cs_pin`=0 and the divider runs. After 16 rising and 16 falling `sclk` edges, go to GAP.
  - GAP: `cs_pin`=1, `sclk_pin`=0. Hold for `2*CLK_DIV*CS_GAP` cycles, then go to IDLE.
- `mosi_pin` changes only on `sclk` falling edges, or on entry to SHIFT for bit 15. The slave samples on rising edges.
- `miso_pin` is sampled in the same `clk` cycle as each `sclk` rising edge. Samples from rising edges 9..16 shift into `rsp_rdata[7:0]`, MSB first.
- Request fields are captured only at the handshake. Input changes afterwards are ignored.
- A `req_valid` held while not ready waits; it is never dropped or duplicated.

## Timing
- Reset values:
  - `cs_pin`=1.
  - `sclk_pin`=0, `mosi_pin`=0.
  - `req_ready`=0; becomes 1 on the first `clk` edge after `rst_n` rises.
  - `rsp_valid`=0, `rsp_rdata`=0, `busy`=0.
  - Divider and bit counter = 0.
- Handshake at edge T0: `cs_pin` falls at T0+1 with `mosi_pin`=bit 15.
- Rising edge k (k = 1..16) occurs at T0+1+`CLK_DIV*(2k-1)`. Falling edge k occurs at T0+1+`CLK_DIV*2k`.
- At the 16th falling edge, T0+1+`32*CLK_DIV`, in the same cycle:
  - `cs_pin` returns to 1.
  - `rsp_valid` pulses for one cycle.
  - `rsp_rdata` is updated.
- `req_ready` reasserts `2*CLK_DIV*CS_GAP` cycles after `cs_pin` rises. With the defaults, request-to-request spacing is 1+256+16 = 273 cycles.
- `busy` = not IDLE. `req_ready` and `busy` are never both high.
- Reset mid-frame: outputs take reset values immediately, with no `rsp_valid` for the aborted frame. The slave abandons its frame when `cs_pin` rises.
- `rsp_rdata` holds its value until the next completed frame.

## Structure
- Shared package `spi_pkg` holds:
  - `SPI_ADDR_W`=7, `SPI_DATA_W`=8, `SPI_FRAME_BITS`=16.
  - `SPI_RW_READ`=1'b1, `SPI_RW_WRITE`=1'b0.
  - `spi_mst_state_t` enum: IDLE, SHIFT, GAP.
- Sub-module `spi_sclk_gen`:
  - Divider producing one-cycle `rise_tick` and `fall_tick` strobes and the `sclk` level.
  - Enabled only in SHIFT; cleared to 0 when disabled.
- Top level holds the FSM, 16-bit shift register, 5-bit bit counter and gap counter.

## Test plan
- Write 0x01 to address 0x00 → `mosi_pin` sequence at rising edges is 0000000_0_00000001. `rsp_valid` pulses at T0+257 with `rsp_rdata`=0x00.
- Read address 0x00 against `spiMemory` → `rsp_rdata`=0x01. `mosi_pin`=0 during data bits.
- Write 0x0F to 0x07, then read 0x07 → `rsp_rdata`=0x0F. Re-read 0x00 → 0x01.
- `req_valid` held high for 3 back-to-back requests → exactly 3 handshakes, each 273 cycles apart. `cs_pin` high for exactly 16 cycles between frames.
- `CLK_DIV`=2 → `sclk_pin` period is 4 cycles. Read of 0x07 → 0x0F.
- `rst_n` pulsed low at rising edge 10 of a read → `cs_pin`=1 and `sclk_pin`=0 immediately, no `rsp_valid`. A following read of 0x00 returns 0x01.
